// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-wide RAM port arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 3;

  localparam logic [1:0] STAT_INIT = 2'b00;
  localparam logic [1:0] STAT_BUSY = 2'b01;
  localparam logic [1:0] STAT_DONE = 2'b10;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  // Transfer descriptor handed to the byte sequencer at grant time
  typedef struct packed {
    logic              we;
    logic [CNT_W-1:0]  nbytes;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } xfer_t;

  // Size code 3 is treated as a word
  function automatic logic [CNT_W-1:0] size_to_nbytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return CNT_W'(1);
      SIZE_HALF: return CNT_W'(2);
      default:   return CNT_W'(4);
    endcase
  endfunction

  function automatic logic [1:0] status_of(input state_e st, input logic mine);
    if (!mine)                          return STAT_INIT;
    if (st == S_RD || st == S_WR)       return STAT_BUSY;
    if (st == S_DONE)                   return STAT_DONE;
    return STAT_INIT;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signal bundle of mem_arbiter.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_data;
  logic [1:0]        if_status;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        mem_size;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        mem_status;

  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_size, ram_din,
    output if_data, if_status, mem_rdata, mem_status, ram_dout, ram_a, ram_wr
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_size, ram_din,
    input  if_data, if_status, mem_rdata, mem_status, ram_dout, ram_a, ram_wr
  );

endinterface

// File: rtl/mem_byte_seq.sv
// Byte sequencer: counter, RAM address stepping, write-data shift-out and
// read-data assembly for one 1/2/4-byte transfer.
module mem_byte_seq
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              start,
  input  xfer_t             xfer,
  input  logic              busy,
  input  logic              is_wr,
  input  logic [7:0]        ram_din,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              wr_en,
  output logic              last_c,
  output logic [DATA_W-1:0] rdata_c
);

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  nbytes_q;
  logic [DATA_W-9:0] wbuf_q;
  logic [DATA_W-1:0] rbuf_q;
  logic              more_c;

  // Reads need one extra cycle because RAM data trails the address by a cycle
  always_comb begin
    more_c = cnt_q < (nbytes_q - CNT_W'(1));
    last_c = 1'b0;
    if (busy) begin
      last_c = is_wr ? (cnt_q == nbytes_q - CNT_W'(1)) : (cnt_q == nbytes_q);
    end
  end

  // Byte k arrives while the counter reads k+1
  always_comb begin
    rdata_c = rbuf_q;
    for (int unsigned i = 0; i < DATA_W / 8; i++) begin
      if (cnt_q == CNT_W'(i + 1)) rdata_c[8*i +: 8] = ram_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      nbytes_q <= '0;
      wbuf_q   <= '0;
      rbuf_q   <= '0;
      ram_a    <= '0;
      ram_dout <= '0;
      wr_en    <= 1'b0;
    end else if (rdy) begin
      if (start) begin
        cnt_q    <= '0;
        nbytes_q <= xfer.nbytes;
        ram_a    <= xfer.addr;
        wr_en    <= xfer.we;
        rbuf_q   <= '0;
        if (xfer.we) begin
          ram_dout <= xfer.wdata[7:0];
          wbuf_q   <= xfer.wdata[DATA_W-1:8];
        end
      end else if (busy) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (more_c) begin
          ram_a <= ram_a + ADDR_W'(1);
          if (is_wr) begin
            ram_dout <= wbuf_q[7:0];
            wbuf_q   <= wbuf_q >> 8;
          end
        end
        if (is_wr && last_c) wr_en <= 1'b0;
        if (!is_wr && cnt_q != '0) rbuf_q <= rdata_c;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM port between instruction fetch and load/store.
// Define MEM_ARBITER_RR_EN for round-robin tie-breaking instead of MEM priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rdy,
  mem_arbiter_if.slave  bus
);

  state_e            state_q, state_nxt_c;
  owner_e            owner_q, owner_nxt_c;
  logic              grant_mem_c;
  logic              start_c;
  xfer_t             xfer_c;
  logic [1:0]        if_status_q, mem_status_q;
  logic [DATA_W-1:0] if_data_q, mem_rdata_q;
  logic              busy_c, is_wr_c, last_c, wr_en;
  logic [DATA_W-1:0] rdata_c;
  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;

`ifdef MEM_ARBITER_RR_EN
  owner_e            last_owner_q;
`endif

  assign busy_c  = (state_q == S_RD) || (state_q == S_WR);
  assign is_wr_c = (state_q == S_WR);

  // Arbitration, request capture and next-state logic
  always_comb begin
    state_nxt_c = state_q;
    owner_nxt_c = owner_q;
    start_c     = 1'b0;
    grant_mem_c = bus.mem_req;
`ifdef MEM_ARBITER_RR_EN
    if (bus.mem_req && bus.if_req) grant_mem_c = (last_owner_q == OWN_IF);
`endif
    xfer_c        = '0;
    xfer_c.we     = grant_mem_c & bus.mem_we;
    xfer_c.nbytes = grant_mem_c ? size_to_nbytes(bus.mem_size) : CNT_W'(4);
    xfer_c.addr   = grant_mem_c ? bus.mem_addr : bus.if_addr;
    xfer_c.wdata  = bus.mem_wdata;

    case (state_q)
      S_IDLE: begin
        if (bus.if_req || bus.mem_req) begin
          start_c     = 1'b1;
          owner_nxt_c = grant_mem_c ? OWN_MEM : OWN_IF;
          state_nxt_c = xfer_c.we ? S_WR : S_RD;
        end
      end
      S_RD, S_WR: begin
        if (last_c) state_nxt_c = S_DONE;
      end
      S_DONE:  state_nxt_c = S_IDLE;
      default: state_nxt_c = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IF;
      if_status_q  <= STAT_INIT;
      mem_status_q <= STAT_INIT;
      if_data_q    <= '0;
      mem_rdata_q  <= '0;
`ifdef MEM_ARBITER_RR_EN
      last_owner_q <= OWN_IF;
`endif
    end else if (rdy) begin
      state_q      <= state_nxt_c;
      owner_q      <= owner_nxt_c;
      if_status_q  <= status_of(state_nxt_c, owner_nxt_c == OWN_IF);
      mem_status_q <= status_of(state_nxt_c, owner_nxt_c == OWN_MEM);
      // Requester data is only replaced once the full read has been assembled
      if (state_q == S_RD && last_c) begin
        if (owner_q == OWN_IF) if_data_q   <= rdata_c;
        else                   mem_rdata_q <= rdata_c;
      end
`ifdef MEM_ARBITER_RR_EN
      if (start_c) last_owner_q <= owner_nxt_c;
`endif
    end
  end

  mem_byte_seq u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .rdy      (rdy),
    .start    (start_c),
    .xfer     (xfer_c),
    .busy     (busy_c),
    .is_wr    (is_wr_c),
    .ram_din  (bus.ram_din),
    .ram_a    (ram_a),
    .ram_dout (ram_dout),
    .wr_en    (wr_en),
    .last_c   (last_c),
    .rdata_c  (rdata_c)
  );

  assign bus.if_data    = if_data_q;
  assign bus.if_status  = if_status_q;
  assign bus.mem_rdata  = mem_rdata_q;
  assign bus.mem_status = mem_status_q;
  assign bus.ram_a      = ram_a;
  assign bus.ram_dout   = ram_dout;
  // A stalled cycle must never write
  assign bus.ram_wr     = wr_en & rdy;

endmodule
